// File: rtl/stack16_bus_arbiter.sv
// Memory bus arbiter for the stack16 CPU plus NREQ DMA requesters: fixed CPU priority,
// round-robin DMA, starvation guard, wait-state stretch. Optional bus locking: STACK16_BUS_LOCK_EN.
module stack16_bus_arbiter #(
    parameter int NREQ        = 2,
    parameter int WAIT_STATES = 1,
    parameter int CPU_RUN_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [15:0]          cpu_addr,
    input  logic [15:0]          cpu_wdata,
    output logic                 cpu_ready,
    input  logic [NREQ-1:0]      dma_req,
    input  logic [NREQ-1:0]      dma_we,
    input  logic [16*NREQ-1:0]   dma_addr,
    input  logic [16*NREQ-1:0]   dma_wdata,
    output logic [NREQ-1:0]      dma_ready,
`ifdef STACK16_BUS_LOCK_EN
    input  logic                 cpu_lock,
    input  logic [NREQ-1:0]      dma_lock,
`endif
    output logic [15:0]          rdata,
    output logic [15:0]          mem_addr,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [2:0]           bus_owner
);

    localparam int WCNT_W = 3;
    localparam int PTR_W  = 2;
    localparam int RUN_W  = $clog2(CPU_RUN_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CPU_RUN_MAX);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          owner_q, owner_d;
    logic                we_q, we_d;
    logic [15:0]         addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [15:0]         rdata_q, rdata_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [RUN_W-1:0]    cpu_run_q, cpu_run_d;
`ifdef STACK16_BUS_LOCK_EN
    logic                lock_q, lock_d;
`endif

    logic                any_dma;
    logic [2*NREQ-1:0]   req_dbl;
    logic [NREQ-1:0]     req_rot;
    logic                grant, g_cpu, g_locked, dma_found;
    logic [PTR_W-1:0]    g_idx;
    int                  win;

    assign any_dma = |dma_req;
    // Rotate requests so bit 0 is the requester at rr_ptr; first set bit is the RR winner.
    assign req_dbl = {dma_req, dma_req};
    assign req_rot = NREQ'(req_dbl >> rr_ptr_q);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wcnt_d    = wcnt_q;
        rdata_d   = rdata_q;
        rr_ptr_d  = rr_ptr_q;
        cpu_run_d = cpu_run_q;
`ifdef STACK16_BUS_LOCK_EN
        lock_d    = lock_q;
`endif
        grant     = 1'b0;
        g_cpu     = 1'b0;
        g_locked  = 1'b0;
        g_idx     = '0;
        dma_found = 1'b0;
        win       = 0;

        case (state_q)
            IDLE: begin
`ifdef STACK16_BUS_LOCK_EN
                if (lock_q && owner_q == 3'd1 && cpu_req) begin
                    grant    = 1'b1;
                    g_cpu    = 1'b1;
                    g_locked = 1'b1;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (lock_q && owner_q == 3'(i + 2) && dma_req[i]) begin
                        grant    = 1'b1;
                        g_idx    = PTR_W'(i);
                        g_locked = 1'b1;
                    end
                end
`endif
                if (!grant) begin
                    if (cpu_req && (!any_dma || cpu_run_q < RUN_MAX)) begin
                        grant = 1'b1;
                        g_cpu = 1'b1;
                    end else begin
                        for (int j = 0; j < NREQ; j++) begin
                            if (!dma_found && req_rot[j]) begin
                                dma_found = 1'b1;
                                win = int'(rr_ptr_q) + j;
                                if (win >= NREQ) win = win - NREQ;
                            end
                        end
                        if (dma_found) begin
                            grant = 1'b1;
                            g_idx = PTR_W'(win);
                        end
                    end
                end

                if (grant) begin
                    if (g_cpu) begin
                        owner_d = 3'd1;
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        owner_d = 3'(g_idx) + 3'd2;
                        for (int i = 0; i < NREQ; i++) begin
                            if (PTR_W'(i) == g_idx) begin
                                we_d    = dma_we[i];
                                addr_d  = dma_addr[16*i +: 16];
                                wdata_d = dma_wdata[16*i +: 16];
                            end
                        end
                    end
                    // Locked re-grants leave fairness state untouched.
                    if (!g_locked) begin
                        if (g_cpu) begin
                            if (!any_dma)
                                cpu_run_d = '0;
                            else if (cpu_run_q != RUN_MAX)
                                cpu_run_d = cpu_run_q + RUN_W'(1);
                        end else begin
                            cpu_run_d = '0;
                            rr_ptr_d  = (int'(g_idx) + 1 >= NREQ) ? '0 : g_idx + PTR_W'(1);
                        end
                    end
                    wcnt_d  = WCNT_W'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else begin
                    if (!we_q) rdata_d = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef STACK16_BUS_LOCK_EN
                lock_d = (owner_q == 3'd1) ? cpu_lock : 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    if (owner_q == 3'(i + 2)) lock_d = dma_lock[i];
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            wcnt_q    <= '0;
            rdata_q   <= '0;
            rr_ptr_q  <= '0;
            cpu_run_q <= '0;
`ifdef STACK16_BUS_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wcnt_q    <= wcnt_d;
            rdata_q   <= rdata_d;
            rr_ptr_q  <= rr_ptr_d;
            cpu_run_q <= cpu_run_d;
`ifdef STACK16_BUS_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign mem_addr  = (state_q == ACCESS) ? addr_q : 16'h0000;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : 16'h0000;
    assign mem_rd    = (state_q == ACCESS) && !we_q;
    assign mem_wr    = (state_q == ACCESS) && we_q;
    assign cpu_ready = (state_q == DONE) && (owner_q == 3'd1);
    assign bus_owner = (state_q == IDLE) ? 3'd0 : owner_q;
    assign rdata     = rdata_q;

    always_comb begin
        dma_ready = '0;
        for (int i = 0; i < NREQ; i++)
            dma_ready[i] = (state_q == DONE) && (owner_q == 3'(i + 2));
    end

endmodule

// File: doc/stack16_bus_arbiter.md
Name: stack16_bus_arbiter

Overview:
- Shares the single 16-bit memory bus between the stack CPU datapath and NREQ DMA-style requesters (e.g. a UART buffer or video fetch).
- Sits between the requesters and the memory/peripheral decoder, and owns mem_addr/mem_rd/mem_wr.
- The CPU has fixed priority. DMA requesters are served round-robin among themselves. A starvation guard forces a DMA slot after a run of CPU grants.
- Every access is stretched by a configurable wait-state count.

Parameters:
- NREQ, 2, number of DMA requesters (1..4)
- WAIT_STATES, 1, extra bus cycles per access (0..7)
- CPU_RUN_MAX, 4, consecutive CPU grants allowed while any DMA request is pending (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  16  CPU address
- cpu_wdata  in  16  CPU write data
- cpu_ready  out  1  one-cycle completion pulse
- dma_req  in  NREQ  per-requester request, held until its ready
- dma_we  in  NREQ  per-requester write flag
- dma_addr  in  16*NREQ  packed addresses, requester i at [16i+15:16i]
- dma_wdata  in  16*NREQ  packed write data
- dma_ready  out  NREQ  one-hot one-cycle completion pulse
- rdata  out  16  read data, valid in the ready cycle, held until next completion
- mem_addr  out  16  bus address
- mem_wdata  out  16  bus write data
- mem_rdata  in  16  bus read data
- mem_rd  out  1  bus read strobe
- mem_wr  out  1  bus write strobe
- bus_owner  out  3  0=none, 1=CPU, 2+i=DMA i (debug)

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration:
  - No requests: stay in IDLE.
  - Otherwise pick a winner:
    - CPU wins if cpu_req=1, and either no dma_req is set or cpu_run < CPU_RUN_MAX.
    - Else the DMA winner is the first set dma_req[i] searching upward from rr_ptr, wrapping modulo NREQ.
  - Latch the winner's owner, we, addr and wdata into registers, load wcnt=WAIT_STATES, go to ACCESS.
- ACCESS:
  - Drive mem_addr and mem_wdata from the latched registers.
  - Assert mem_rd=~we or mem_wr=we.
  - If wcnt!=0, decrement it. If wcnt==0, capture mem_rdata into rdata (reads only) and go to DONE.
  - Strobe width is exactly WAIT_STATES+1 cycles.
- DONE:
  - Strobes low. Pulse the owner's ready for exactly one cycle. Return to IDLE.
  - Throughput: one access per WAIT_STATES+3 cycles.
- Counters:
  - cpu_run increments (saturating at CPU_RUN_MAX) on each CPU grant while any dma_req=1.
  - cpu_run clears on any DMA grant, or on a CPU grant when no dma_req is set.
  - rr_ptr updates to (winner+1) mod NREQ on each DMA grant only.
- Request rules:
  - Requests are sampled only in IDLE.
  - A request deasserted mid-access does not abort the access; the strobe and ready pulse still complete.
  - Requester inputs change after latching have no effect.
- Writes: rdata is unchanged.
- Outputs outside ACCESS: mem_addr=0, mem_wdata=0.
- Reset, including mid-access:
  - Next edge: state=IDLE, mem_rd=mem_wr=0, all ready=0, rdata=0, bus_owner=0, rr_ptr=0, cpu_run=0, wcnt=0.
  - The interrupted access is dropped without a ready pulse.

Optional Feature:
- Macro: STACK16_BUS_LOCK_EN.
- With it defined:
  - Extra inputs cpu_lock and dma_lock[NREQ].
  - If the current owner's lock=1 in DONE, the next IDLE arbitration grants that same owner whenever it requests, bypassing priority and the starvation guard.
  - cpu_run and rr_ptr are not updated for locked re-grants.
  - The lock is released when lock=0 at DONE.
- Without it: ports absent, arbitration as above.

Test Plan:
- WAIT_STATES=1, CPU read 0x1234, mem_rdata=0xBEEF → mem_rd high 2 cycles with mem_addr=0x1234, cpu_ready pulse in the following cycle, rdata=0xBEEF.
- dma_req=2'b11 held, CPU idle → grants alternate DMA0, DMA1, DMA0; dma_ready pulses match; bus_owner sequence 2,3,2.
- cpu_req held, dma_req[1]=1, CPU_RUN_MAX=4 → 4 CPU accesses, then 1 DMA1 access, then CPU resumes.
- DMA0 write 0x00AA to 0x8000 with WAIT_STATES=0 → mem_wr high 1 cycle with mem_wdata=0x00AA; rdata unchanged.
- Reset asserted in the 2nd ACCESS cycle of a CPU read → next cycle strobes=0, no cpu_ready pulse, bus_owner=0, and the next request is arbitrated from IDLE.
- With STACK16_BUS_LOCK_EN, dma_lock[0]=1 for 3 accesses while cpu_req=1 → DMA0 gets 3 back-to-back grants, then CPU.
